// File: rtl/mrd_stage_sched.sv
// mrd_stage_sched: stage sequencer issuing butterfly-group reads per radix stage, holding each stage until write-back completes
module mrd_stage_sched #(
  parameter int MAX_STAGES = 6,
  parameter int wCNT = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    inverse,
  input  logic [wCNT-1:0]         n_points,
  input  logic [2:0]              n_stages,
  input  logic [3*MAX_STAGES-1:0] factors,
  input  logic                    stall,
  input  logic                    wb_val,
  output logic                    rd_val,
  output logic [wCNT-1:0]         rd_grp,
  output logic [2:0]              factor,
  output logic [2:0]              cnt_stage,
  output logic                    inverse_out,
  output logic                    busy,
  output logic                    stage_end,
  output logic                    done,
  output logic                    cfg_err,
  output logic                    wb_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NEXT, DONE} state_t;
  localparam logic [3:0]      MAX_S = 4'(MAX_STAGES);
  localparam logic [wCNT-1:0] ONE   = wCNT'(1);
  state_t                    state;
  logic [wCNT-1:0]           grp_cnt, pts_cnt, wb_cnt, n_points_q;
  logic [2:0]                n_stages_q;
  logic [3*MAX_STAGES-1:0]   factors_q;
  logic                      cfg_bad, issue, last_rd, wb_act, wb_ok, complete;
  assign issue     = state == ISSUE && !stall;
  assign last_rd   = issue && ({1'b0, pts_cnt} + {{(wCNT-2){1'b0}}, factor} >= {1'b0, n_points_q});
  assign wb_act    = wb_val && (state == ISSUE || state == DRAIN);
  assign wb_ok     = wb_act && wb_cnt != grp_cnt;
  assign complete  = state == DRAIN && (wb_cnt == grp_cnt || (wb_ok && wb_cnt + ONE == grp_cnt));
  assign rd_val    = issue;
  assign rd_grp    = grp_cnt;
  assign busy      = state != IDLE;
  assign stage_end = complete;
  assign done      = state == DONE;
  // reject a start whose stage count, size or any active-stage radix is unusable
  always_comb begin
    cfg_bad = n_stages == 3'd0 || {1'b0, n_stages} > MAX_S || n_points == '0;
    for (int k = 0; k < MAX_STAGES; k++)
      if (k < int'(n_stages) && (factors[3*k +: 3] < 3'd2 || factors[3*k +: 3] > 3'd5)) cfg_bad = 1'b1;
  end
  // stage sequencing, group/point/write-back counters and latched configuration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grp_cnt     <= '0;
      pts_cnt     <= '0;
      wb_cnt      <= '0;
      n_points_q  <= '0;
      n_stages_q  <= '0;
      factors_q   <= '0;
      factor      <= '0;
      cnt_stage   <= '0;
      inverse_out <= 1'b0;
      cfg_err     <= 1'b0;
      wb_err      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (wb_act && !wb_ok) wb_err <= 1'b1;
      if (wb_ok) wb_cnt <= wb_cnt + ONE;
      if (issue) begin
        grp_cnt <= grp_cnt + ONE;
        pts_cnt <= pts_cnt + {{(wCNT-3){1'b0}}, factor};
      end
      case (state)
        IDLE: if (start) begin
          if (cfg_bad) cfg_err <= 1'b1;
          else begin
            n_points_q  <= n_points;
            n_stages_q  <= n_stages;
            factors_q   <= factors;
            inverse_out <= inverse;
            factor      <= factors[2:0];
            cnt_stage   <= '0;
            grp_cnt     <= '0;
            pts_cnt     <= '0;
            wb_cnt      <= '0;
            wb_err      <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: if (last_rd) state <= DRAIN;
        DRAIN: if (complete) state <= cnt_stage == n_stages_q - 3'd1 ? DONE : NEXT;
        NEXT: begin
          cnt_stage <= cnt_stage + 3'd1;
          factor    <= factors_q[3*(int'(cnt_stage)+1) +: 3];
          grp_cnt   <= '0;
          pts_cnt   <= '0;
          wb_cnt    <= '0;
          state     <= ISSUE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mrd_stage_sched.md
Name: mrd_stage_sched

Overview:
- Stage sequencer for the mixed-radix 2/3/4/5 DFT engine.
- Walks a configured factor list one stage at a time, issuing one butterfly-group read per cycle to the memory address generator.
- Tags each issued group with factor, cnt_stage and inverse.
- Holds the next stage until every group of the current stage has been written back by the radix/twiddle unit. This protects in-place memory between stages.

Parameters:
- MAX_STAGES, 6, maximum number of radix stages per transform.
- wCNT, 11, width of point and group counters; N max 2047.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; launches a transform when idle
- inverse  in  1  IDFT select, sampled at accepted start
- n_points  in  wCNT  transform size N, sampled at start
- n_stages  in  3  number of stages (1..MAX_STAGES), sampled at start
- factors  in  3*MAX_STAGES  factor of stage k in bits [3k+2:3k], sampled at start
- stall  in  1  memory side cannot accept a read this cycle
- wb_val  in  1  one group written back (radix/twiddle output valid)
- rd_val  out  1  group read issued this cycle
- rd_grp  out  wCNT  group index within current stage
- factor  out  3  radix of current stage
- cnt_stage  out  3  current stage index
- inverse_out  out  1  latched inverse flag
- busy  out  1  transform in progress
- stage_end  out  1  pulse, last write-back of a stage seen
- done  out  1  pulse, transform complete
- cfg_err  out  1  pulse, start rejected
- wb_err  out  1  sticky, write-back with none outstanding; cleared by accepted start

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - All outputs and counters go to 0.
  - Applies mid-transform: in-flight work is abandoned and no done pulse is produced.
- Start handling:
  - Accepted only in IDLE. A start while busy=1 is ignored, with no effect on state or latched config.
  - The config check fails when n_stages==0, n_stages>MAX_STAGES, n_points==0, or any factor for k<n_stages is not in {2,3,4,5}.
  - On a failed check: cfg_err=1 for one cycle, the block stays IDLE, busy stays 0.
  - On an accepted start: latch config and inverse_out, set cnt_stage=0, clear the counters and wb_err, then go to ISSUE. busy=1 from the next cycle until the cycle after done.
- ISSUE:
  - On every cycle with stall=0: rd_val=1, rd_grp=grp_cnt, grp_cnt+=1, pts_cnt+=factor.
  - On cycles with stall=1: rd_val=0 and counters hold.
  - A read issued with pts_cnt+factor>=n_points is the last of the stage; the next state is DRAIN.
  - factor and cnt_stage are stable for the whole stage.
- Write-back counting:
  - wb_cnt increments on wb_val in ISSUE and DRAIN. Write-backs may overlap issuing.
  - wb_val in IDLE or DONE is ignored.
  - wb_val when wb_cnt==grp_cnt sets wb_err and does not increment.
- DRAIN:
  - The stage completes on the cycle where wb_val brings wb_cnt to grp_cnt. If the last write-back arrived during ISSUE, completion is the first DRAIN cycle.
  - On completion: stage_end=1 for that cycle.
  - Next state is DONE if cnt_stage==n_stages-1, otherwise NEXT.
- NEXT:
  - One bubble cycle with rd_val=0.
  - cnt_stage+=1; grp_cnt, pts_cnt and wb_cnt clear to 0.
  - factor updates to the new stage's factor; next state is ISSUE.
- DONE:
  - done=1 for one cycle, then IDLE with busy=0.
  - A start can be accepted in the IDLE cycle immediately following.
- Latency:
  - First rd_val comes 1 cycle after start is accepted.
  - Minimum gap between the last wb_val of stage k and the first rd_val of stage k+1 is 2 cycles (DRAIN completion, then NEXT).
- Widths: counters are wCNT unsigned. pts_cnt+factor is computed at wCNT+1 bits so it cannot wrap.

Test Plan:
- N=12, factors {4,3}, n_stages=2, no stall, each wb_val 6 cycles after its rd_val:
  - Stage 0: rd_grp 0,1,2 with factor=4.
  - stage_end, then NEXT bubble.
  - Stage 1: rd_grp 0..3 with factor=3, cnt_stage=1.
  - done pulses once; busy drops the following cycle.
- Same config with stall high on cycles 2–4 of stage 0: rd_val is low exactly on those cycles, rd_grp resumes at the held value, and the total is still 3 groups.
- start asserted again mid-stage with different n_points: ignored; the sequence is identical to the first scenario.
- factors {4,7}: cfg_err=1 for one cycle, busy stays 0, no rd_val.
- rst_n=0 during stage 1 of the first scenario: all outputs are 0 the next cycle, no done pulse, and a new start then runs normally.
- wb_val injected in IDLE is ignored. An extra wb_val after a stage is fully written back sets wb_err, which stays set until the next accepted start.
